mix_grad_accum_gen: RTL

- Parametrised gradient accumulator for the mix layers' backward pass.
- Per start request, adds the outer product d_forward^T x d_backward into the selected layer's weight-gradient RAM, DATA_N lanes per cycle, and adds d_backward into the bias-gradient RAM.
- Generalises the fixed single-purpose accumulator:
  - any HID_DIM, DATA_N and layer count;
  - start/busy/done handshake;
  - explicit write enables;
  - per-request clear mode, so the first sample of a batch overwrites rather than accumulates.
- Sits between the mix-layer backward datapath and the gradient RAMs feeding the optimizer.

---
 rtl/mix_grad_accum_gen.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/mix_grad_accum_gen.sv
// Outer-product weight/bias gradient accumulator for the mix-layer backward pass.
// Define GRAD_SAT_EN for saturating arithmetic and the sticky o_sat_flag output.
module mix_grad_accum_gen #(
  parameter int HID_DIM    = 32,
  parameter int DATA_N     = 8,
  parameter int N_LEN      = 16,
  parameter int F_LEN      = 8,
  parameter int W_LEN      = 16,
  parameter int N_LAYER    = 3,
  parameter int ADDR_WIDTH = 9,
  localparam int LAYER_W   = (N_LAYER > 1) ? $clog2(N_LAYER) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
`ifdef GRAD_SAT_EN
  output logic                      o_sat_flag,
`endif
  input  logic                      i_start,
  input  logic [LAYER_W-1:0]        i_layer,
  input  logic                      i_clear,
  input  logic [HID_DIM*N_LEN-1:0]  i_d_forward,
  input  logic [HID_DIM*N_LEN-1:0]  i_d_backward,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_err,
  output logic [ADDR_WIDTH-1:0]     o_raddr_w,
  input  logic [DATA_N*W_LEN-1:0]   i_rdata_w,
  output logic                      o_we_w,
  output logic [ADDR_WIDTH-1:0]     o_waddr_w,
  output logic [DATA_N*W_LEN-1:0]   o_wdata_w,
  output logic [ADDR_WIDTH-1:0]     o_raddr_b,
  input  logic [W_LEN-1:0]          i_rdata_b,
  output logic                      o_we_b,
  output logic [ADDR_WIDTH-1:0]     o_waddr_b,
  output logic [W_LEN-1:0]          o_wdata_b
);

  localparam int W  = HID_DIM * HID_DIM / DATA_N;
  localparam int G  = HID_DIM / DATA_N;
  localparam int KW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = (HID_DIM > 1) ? $clog2(HID_DIM) : 1;
  localparam int CW = (G > 1) ? $clog2(G) : 1;
  localparam int PW = 2 * N_LEN;
  localparam int SW = ((W_LEN > N_LEN) ? W_LEN : N_LEN) + 1;

`ifdef GRAD_SAT_EN
  localparam logic signed [PW-1:0] P_MAX = {{(PW-W_LEN+1){1'b0}}, {(W_LEN-1){1'b1}}};
  localparam logic signed [PW-1:0] P_MIN = {{(PW-W_LEN+1){1'b1}}, {(W_LEN-1){1'b0}}};
  localparam logic signed [SW-1:0] S_MAX = {{(SW-W_LEN+1){1'b0}}, {(W_LEN-1){1'b1}}};
  localparam logic signed [SW-1:0] S_MIN = {{(SW-W_LEN+1){1'b1}}, {(W_LEN-1){1'b0}}};
  localparam logic [W_LEN-1:0]     W_MAX = {1'b0, {(W_LEN-1){1'b1}}};
  localparam logic [W_LEN-1:0]     W_MIN = {1'b1, {(W_LEN-1){1'b0}}};

  // Results carry a clamp flag in the MSB.
  function automatic logic [W_LEN:0] f_prod(input logic signed [N_LEN-1:0] a,
                                            input logic signed [N_LEN-1:0] b);
    logic signed [PW-1:0] m;
    m = a * b;
    m = m >>> F_LEN;
    if (m > P_MAX)      f_prod = {1'b1, W_MAX};
    else if (m < P_MIN) f_prod = {1'b1, W_MIN};
    else                f_prod = {1'b0, m[W_LEN-1:0]};
  endfunction

  function automatic logic [W_LEN:0] f_sum(input logic signed [SW-1:0] a,
                                           input logic signed [SW-1:0] b);
    logic signed [SW-1:0] s;
    s = a + b;
    if (s > S_MAX)      f_sum = {1'b1, W_MAX};
    else if (s < S_MIN) f_sum = {1'b1, W_MIN};
    else                f_sum = {1'b0, s[W_LEN-1:0]};
  endfunction
`else
  function automatic logic [W_LEN-1:0] f_prod(input logic signed [N_LEN-1:0] a,
                                              input logic signed [N_LEN-1:0] b);
    logic signed [PW-1:0] m;
    m = a * b;
    f_prod = m[F_LEN +: W_LEN];
  endfunction

  function automatic logic [W_LEN-1:0] f_sum(input logic signed [SW-1:0] a,
                                             input logic signed [SW-1:0] b);
    logic signed [SW-1:0] s;
    s = a + b;
    f_sum = s[W_LEN-1:0];
  endfunction
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                    r_state, w_next;
  logic                      w_accept, w_reject, w_last, w_layer_ok;
  logic [KW-1:0]             r_k;
  logic [RW-1:0]             r_row;
  logic [CW-1:0]             r_col;
  logic                      r_drain, r_done, r_err, r_clear;
  logic [LAYER_W-1:0]        r_layer;
  logic [HID_DIM*N_LEN-1:0]  r_fwd, r_bwd;
  logic [ADDR_WIDTH-1:0]     r_raddr_w, r_raddr_b, w_base_w, w_base_b;
  logic                      w_issue_w, w_issue_b;
  logic                      r_v1w, r_v1b;
  logic [ADDR_WIDTH-1:0]     r_a1w, r_a1b;
  logic [DATA_N*W_LEN-1:0]   w_prod, r_prod, w_wsum;
  logic [N_LEN-1:0]          w_bgrad, r_bgrad;
  logic [W_LEN-1:0]          w_bsum;
  logic                      r_we_w, r_we_b;
  logic [ADDR_WIDTH-1:0]     r_waddr_w, r_waddr_b;
  logic [DATA_N*W_LEN-1:0]   r_wdata_w;
  logic [W_LEN-1:0]          r_wdata_b;

  assign w_layer_ok = ({1'b0, i_layer} < (LAYER_W+1)'(N_LAYER));
  assign w_base_w   = ADDR_WIDTH'(i_layer) * ADDR_WIDTH'(W);
  assign w_base_b   = ADDR_WIDTH'(i_layer) * ADDR_WIDTH'(HID_DIM);
  assign w_issue_w  = (r_state == S_RUN);
  assign w_issue_b  = (r_state == S_RUN) && ({1'b0, r_k} < (KW+1)'(HID_DIM));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_reject = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start && w_layer_ok) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end else if (i_start) begin
          w_reject = 1'b1;
        end
      end
      S_RUN:   if (r_k == KW'(W-1)) w_next = S_DRAIN;
      S_DRAIN: if (r_drain) begin
        w_next = S_IDLE;
        w_last = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture and issue-side counters; read addresses freeze outside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;  r_err <= 1'b0;  r_drain <= 1'b0;  r_clear <= 1'b0;
      r_k <= '0;  r_row <= '0;  r_col <= '0;  r_layer <= '0;
      r_fwd <= '0;  r_bwd <= '0;  r_raddr_w <= '0;  r_raddr_b <= '0;
    end else begin
      r_done <= w_last;
      r_err  <= w_reject;
      if (w_accept) begin
        r_fwd     <= i_d_forward;
        r_bwd     <= i_d_backward;
        r_layer   <= i_layer;
        r_clear   <= i_clear;
        r_k       <= '0;
        r_row     <= '0;
        r_col     <= '0;
        r_drain   <= 1'b0;
        r_raddr_w <= w_base_w;
        r_raddr_b <= w_base_b;
      end else if (r_state == S_RUN) begin
        if (r_k != KW'(W-1)) begin
          r_k       <= r_k + 1'b1;
          r_raddr_w <= r_raddr_w + 1'b1;
          if (r_col == CW'(G-1)) begin
            r_col <= '0;
            r_row <= r_row + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        if ({1'b0, r_k} < (KW+1)'(HID_DIM-1)) r_raddr_b <= r_raddr_b + 1'b1;
      end else if (r_state == S_DRAIN) begin
        r_drain <= 1'b1;
      end
    end
  end

`ifdef GRAD_SAT_EN
  logic [W_LEN:0] w_pt, w_st, w_bt;
  logic           w_prod_clamp, w_wsum_clamp, w_bsum_clamp, r_sat;
`endif

  always_comb begin
    w_prod  = '0;
    w_wsum  = '0;
    w_bgrad = r_bwd[int'(r_k)*N_LEN +: N_LEN];
`ifdef GRAD_SAT_EN
    w_pt = '0;  w_st = '0;
    w_prod_clamp = 1'b0;
    w_wsum_clamp = 1'b0;
    for (int i = 0; i < DATA_N; i++) begin
      w_pt = f_prod(r_fwd[int'(r_row)*N_LEN +: N_LEN],
                    r_bwd[(int'(r_col)*DATA_N + i)*N_LEN +: N_LEN]);
      w_prod[i*W_LEN +: W_LEN] = w_pt[W_LEN-1:0];
      w_prod_clamp = w_prod_clamp | w_pt[W_LEN];
      w_st = f_sum(r_clear ? '0 : SW'($signed(i_rdata_w[i*W_LEN +: W_LEN])),
                   SW'($signed(r_prod[i*W_LEN +: W_LEN])));
      w_wsum[i*W_LEN +: W_LEN] = w_st[W_LEN-1:0];
      w_wsum_clamp = w_wsum_clamp | w_st[W_LEN];
    end
    w_bt = f_sum(r_clear ? '0 : SW'($signed(i_rdata_b)), SW'($signed(r_bgrad)));
    w_bsum = w_bt[W_LEN-1:0];
    w_bsum_clamp = w_bt[W_LEN];
`else
    for (int i = 0; i < DATA_N; i++) begin
      w_prod[i*W_LEN +: W_LEN] = f_prod(r_fwd[int'(r_row)*N_LEN +: N_LEN],
                                        r_bwd[(int'(r_col)*DATA_N + i)*N_LEN +: N_LEN]);
      w_wsum[i*W_LEN +: W_LEN] = f_sum(r_clear ? '0 : SW'($signed(i_rdata_w[i*W_LEN +: W_LEN])),
                                       SW'($signed(r_prod[i*W_LEN +: W_LEN])));
    end
    w_bsum = f_sum(r_clear ? '0 : SW'($signed(i_rdata_b)), SW'($signed(r_bgrad)));
`endif
  end

  // Stage 1 lines products up with RAM read data; stage 2 is the write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1w <= 1'b0;  r_v1b <= 1'b0;  r_a1w <= '0;  r_a1b <= '0;
      r_prod <= '0;  r_bgrad <= '0;
      r_we_w <= 1'b0;  r_we_b <= 1'b0;  r_waddr_w <= '0;  r_waddr_b <= '0;
      r_wdata_w <= '0;  r_wdata_b <= '0;
    end else begin
      r_v1w  <= w_issue_w;
      r_v1b  <= w_issue_b;
      r_we_w <= r_v1w;
      r_we_b <= r_v1b;
      if (w_issue_w) begin
        r_a1w  <= r_raddr_w;
        r_prod <= w_prod;
      end
      if (w_issue_b) begin
        r_a1b   <= r_raddr_b;
        r_bgrad <= w_bgrad;
      end
      if (r_v1w) begin
        r_waddr_w <= r_a1w;
        r_wdata_w <= w_wsum;
      end
      if (r_v1b) begin
        r_waddr_b <= r_a1b;
        r_wdata_b <= w_bsum;
      end
    end
  end

`ifdef GRAD_SAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_sat <= 1'b0;
    else if (w_accept) r_sat <= 1'b0;
    else if ((w_issue_w && w_prod_clamp) || (r_v1w && w_wsum_clamp) || (r_v1b && w_bsum_clamp))
      r_sat <= 1'b1;
  end
  assign o_sat_flag = r_sat;
`endif

  assign o_busy    = (r_state != S_IDLE);
  assign o_done    = r_done;
  assign o_err     = r_err;
  assign o_raddr_w = r_raddr_w;
  assign o_raddr_b = r_raddr_b;
  assign o_we_w    = r_we_w;
  assign o_waddr_w = r_waddr_w;
  assign o_wdata_w = r_wdata_w;
  assign o_we_b    = r_we_b;
  assign o_waddr_b = r_waddr_b;
  assign o_wdata_b = r_wdata_b;

endmodule
